// File: rtl/mul_b2_seq_pkg.sv
// mul_b2_seq_pkg: shared state type and width helpers for the b2 sequential multiplier
package mul_b2_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    function automatic int d_of(input int w);
        return w / 2;
    endfunction

    function automatic int cnt_w_of(input int w);
        return (w / 2 > 1) ? $clog2(w / 2) : 1;
    endfunction

    function automatic int acc_w_of(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/mul_b2_comb.sv
// mul_b2_comb: 2-bit x 2-bit unsigned product from a 16-entry table
module mul_b2_comb (
    input  logic [1:0] x,
    input  logic [1:0] y,
    output logic [3:0] p
);

    // nibble at index {x,y} holds x*y
    localparam logic [63:0] TBL = 64'h9630_6420_3210_0000;

    assign p = TBL[{x, y, 2'b00} +: 4];

endmodule

// File: rtl/mul_b2_seq_ctrl.sv
// mul_b2_seq_ctrl: iterative WxW multiplier walking D*D digit pairs through one 2x2 product unit
module mul_b2_seq_ctrl
    import mul_b2_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           clr,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] q,
    output logic           busy
);

    localparam int D  = d_of(W);
    localparam int CW = cnt_w_of(W);
    localparam int AW = acc_w_of(W);
    localparam int SW = $clog2(AW);

    state_t        st;
    logic [W-1:0]  a_r, b_r;
    logic [CW-1:0] i, j;
    logic [3:0]    p_q, pp;
    logic [SW-1:0] s_q;
    logic          pv;
    logic [AW-1:0] acc, acc_nx;
    logic          last_i, last_j;

    mul_b2_comb u_mul (
        .x(a_r[{i, 1'b0} +: 2]),
        .y(b_r[{j, 1'b0} +: 2]),
        .p(pp)
    );

    assign last_i = i == CW'(D - 1);
    assign last_j = j == CW'(D - 1);
    assign acc_nx = pv ? acc + (AW'(p_q) << s_q) : acc;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st        <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            q         <= '0;
            acc       <= '0;
            pv        <= 1'b0;
            p_q       <= '0;
            s_q       <= '0;
            i         <= '0;
            j         <= '0;
            a_r       <= '0;
            b_r       <= '0;
        end else if (clr) begin
            st        <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            q         <= '0;
            acc       <= '0;
            pv        <= 1'b0;
        end else begin
            acc <= acc_nx;
            pv  <= 1'b0;
            case (st)
                IDLE: if (in_valid) begin
                    a_r      <= a;
                    b_r      <= b;
                    acc      <= '0;
                    i        <= '0;
                    j        <= '0;
                    st       <= RUN;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                end
                RUN: begin
                    p_q <= pp;
                    s_q <= SW'({i, 1'b0}) + SW'({j, 1'b0});
                    pv  <= 1'b1;
                    j   <= last_j ? '0 : j + 1'b1;
                    if (last_j) i <= last_i ? '0 : i + 1'b1;
                    if (last_i && last_j) st <= DRAIN;
                end
                // last partial product lands in q directly, no extra cycle
                DRAIN: begin
                    q         <= acc_nx;
                    st        <= DONE;
                    busy      <= 1'b0;
                    out_valid <= 1'b1;
                end
                DONE: if (out_ready) begin
                    st        <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_b2_seq_ctrl.sv
// tb_mul_b2_seq_ctrl: directed and random checks of mul_b2_seq_ctrl against a cycle-count reference model
module tb_mul_b2_seq_ctrl;

    logic        clk, rstn, clr;
    logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] q8;
    logic        in_valid4, in_ready4, out_valid4, out_ready4, busy4;
    logic [3:0]  a4, b4;
    logic [7:0]  q4;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 0;

    mul_b2_seq_ctrl #(.W(8)) dut8 (
        .clk(clk), .rstn(rstn), .clr(clr),
        .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
        .out_valid(out_valid8), .out_ready(out_ready8), .q(q8), .busy(busy8)
    );

    mul_b2_seq_ctrl #(.W(4)) dut4 (
        .clk(clk), .rstn(rstn), .clr(clr),
        .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
        .out_valid(out_valid4), .out_ready(out_ready4), .q(q4), .busy(busy4)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference for the W=8 instance: idle / busy for D*D+1 edges / done holding a*b
    int          m_st;
    int          m_cnt;
    logic [7:0]  m_a, m_b;
    logic [15:0] m_q;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_st = 0;
            m_q  = '0;
        end else if (clr) begin
            m_st = 0;
            m_q  = '0;
        end else if (m_st == 0) begin
            if (in_valid8) begin
                m_st  = 1;
                m_cnt = 0;
                m_a   = a8;
                m_b   = b8;
            end
        end else if (m_st == 1) begin
            m_cnt++;
            if (m_cnt == 17) begin
                m_st = 2;
                m_q  = {8'b0, m_a} * {8'b0, m_b};
            end
        end else if (out_ready8) begin
            m_st = 0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_in_ready", in_ready8, m_st == 0);
            chk("m_busy", busy8, m_st == 1);
            chk("m_out_valid", out_valid8, m_st == 2);
            chk("m_q", q8, m_q);
        end
    end

    task automatic op8(input logic [7:0] x, input logic [7:0] y, input int hold, input bit poke,
                       input logic [15:0] exp);
        int lat;
        @(negedge clk);
        chk("idle_ready", in_ready8, 1);
        a8 = x; b8 = y; in_valid8 = 1; out_ready8 = (hold == 0);
        @(negedge clk);
        in_valid8 = 0; a8 = 8'($urandom); b8 = 8'($urandom);
        chk("accept_busy", busy8, 1);
        chk("accept_not_ready", in_ready8, 0);
        lat = 0;
        while (!out_valid8 && lat < 64) begin
            if (poke && lat >= 2 && lat < 8) begin
                in_valid8 = 1; a8 = 8'h11;
            end else in_valid8 = 0;
            @(negedge clk);
            lat++;
        end
        in_valid8 = 0;
        chk("latency", lat, 17);
        chk("result", q8, exp);
        for (int c = 0; c < hold; c++) begin
            in_valid8 = 1'($urandom); a8 = 8'($urandom);
            @(negedge clk);
            chk("hold_valid", out_valid8, 1);
            chk("hold_q", q8, exp);
            chk("hold_ready", in_ready8, 0);
        end
        in_valid8 = 0; out_ready8 = 1;
        @(negedge clk);
        chk("release_valid", out_valid8, 0);
        chk("release_ready", in_ready8, 1);
        chk("q_kept", q8, exp);
        out_ready8 = 0;
    endtask

    initial begin
        int lat;
        rstn = 0; clr = 0;
        in_valid8 = 0; a8 = 0; b8 = 0; out_ready8 = 0;
        in_valid4 = 0; a4 = 0; b4 = 0; out_ready4 = 0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready8, 1);
        chk("rst_out_valid", out_valid8, 0);
        chk("rst_busy", busy8, 0);
        chk("rst_q", q8, 0);
        chk("rst4_q", q4, 0);
        rstn = 1;
        cmp_en = 1;

        op8(8'h03, 8'h05, 0, 0, 16'h000F);
        op8(8'hFF, 8'hFF, 0, 0, 16'hFE01);
        op8(8'h00, 8'hA5, 0, 0, 16'h0000);
        op8(8'h80, 8'h02, 0, 0, 16'h0100);
        op8(8'h12, 8'h34, 5, 0, 16'h03A8);
        op8(8'h0F, 8'h0E, 0, 1, 16'h00D2);
        op8(8'h03, 8'h05, 2, 0, 16'h000F);

        // abort at issue 7, while a result is still visible from the previous op
        op8(8'h12, 8'h34, 0, 0, 16'h03A8);
        @(negedge clk);
        a8 = 8'hAB; b8 = 8'hCD; in_valid8 = 1; out_ready8 = 1;
        @(negedge clk);
        in_valid8 = 0;
        repeat (7) @(negedge clk);
        clr = 1; in_valid8 = 1;
        @(negedge clk);
        clr = 0; in_valid8 = 0;
        chk("clr_q", q8, 0);
        chk("clr_out_valid", out_valid8, 0);
        chk("clr_in_ready", in_ready8, 1);
        chk("clr_busy", busy8, 0);
        out_ready8 = 0;
        op8(8'hAB, 8'hCD, 0, 0, 16'h88EF);

        // asynchronous reset mid-RUN
        @(negedge clk);
        a8 = 8'h77; b8 = 8'h99; in_valid8 = 1;
        @(negedge clk);
        in_valid8 = 0;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", busy8, 1);
        #2 rstn = 0;
        #1;
        chk("arst_in_ready", in_ready8, 1);
        chk("arst_out_valid", out_valid8, 0);
        chk("arst_busy", busy8, 0);
        chk("arst_q", q8, 0);
        @(negedge clk);
        rstn = 1;

        // W=4 instance
        @(negedge clk);
        a4 = 4'hF; b4 = 4'hF; in_valid4 = 1; out_ready4 = 1;
        @(negedge clk);
        in_valid4 = 0;
        chk("w4_busy", busy4, 1);
        lat = 0;
        while (!out_valid4 && lat < 32) begin
            @(negedge clk);
            lat++;
        end
        chk("w4_latency", lat, 5);
        chk("w4_q", q4, 8'hE1);
        @(negedge clk);
        chk("w4_release", out_valid4, 0);
        chk("w4_q_kept", q4, 8'hE1);
        out_ready4 = 0;

        // random traffic on the W=8 instance, checked by the model each cycle
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            in_valid8  = 1'($urandom);
            a8         = 8'($urandom);
            b8         = 8'($urandom);
            out_ready8 = ($urandom % 4) != 0;
            clr        = ($urandom % 80) == 0;
        end
        @(negedge clk);
        in_valid8 = 0; clr = 0; out_ready8 = 0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mul_b2_seq_ctrl.md
Name: mul_b2_seq_ctrl

Overview:
Iterative unsigned W×W multiplier sequencer built around a single shared 2-bit × 2-bit product unit.
- Accepts one operand pair over a valid/ready handshake.
- Walks all D×D digit pairs, one per cycle (D = W/2), and shift-accumulates the partial products into a 2W-bit result.
- Returns the result over a second valid/ready handshake.
- Intended as the area-minimal multiply engine beside the b2 multiplier library, for control paths where latency is irrelevant.

Parameters:
W, 8, operand width in bits; must be even and ≥ 2 (D = W/2 digits).

Ports:
clk  input  1  clock, all state on rising edge
rstn  input  1  reset, asynchronous, active-low
clr  input  1  synchronous abort; highest priority after rstn
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands
a  input  W  unsigned multiplicand
b  input  W  unsigned multiplier
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
q  output  2W  unsigned product a*b
busy  output  1  high in RUN or DRAIN

Behaviour:
Interface: one clock (clk); reset (rstn) is asynchronous and active-low.

Reset values (rstn=0): state IDLE, in_ready=1, out_valid=0, q=0, busy=0, accumulator=0, product register valid=0.

States:
- IDLE:
  - in_ready=1.
  - Edge with in_valid=1 latches a and b, clears the accumulator, zeros the digit counters and goes to RUN.
- RUN:
  - Each edge issues digit pair (i, j), with i = a-digit index (outer) and j = b-digit index (inner), both 0..D-1.
  - The issue registers p_q = a[2i+1:2i]*b[2j+1:2j] (4 bits) and shift s_q = 2(i+j).
  - After issuing pair (D-1, D-1), go to DRAIN.
- DRAIN:
  - One edge to accumulate the last partial product.
  - Then go to DONE; q ← final accumulator; out_valid=1.
- DONE:
  - out_valid=1; q held stable while out_ready=0.
  - Edge with out_ready=1 goes to IDLE with out_valid=0. q keeps its last value.

Accumulation:
- Any edge on which the product register is valid adds (p_q << s_q), zero-extended to 2W bits, to the accumulator.
- The product register's valid flag is set by each RUN issue and cleared otherwise.
- No overflow is possible: max (2^W-1)^2 < 2^(2W).

Latency:
- Acceptance at edge k; issue n (0..D*D-1) occurs at edge k+1+n; its accumulate occurs at edge k+2+n.
- out_valid rises after edge k+D*D+1. For W=8 that is edge k+17.
- Minimum initiation interval is D*D+3 cycles when out_ready is held at 1.

Handshake rules:
- in_ready is high only in IDLE.
- in_valid in any other state is ignored; the operands are not queued.
- No acceptance occurs in the same cycle as a DONE→IDLE transition.
- in_valid may drop without waiting; a, b are sampled only at acceptance.

busy: 1 in RUN/DRAIN, 0 otherwise.

clr=1 at an edge, from any state:
- Go to IDLE; out_valid=0, q=0, accumulator=0, product register valid=0.
- No result is produced for an aborted operation.
- clr overrides a simultaneous in_valid acceptance and a simultaneous out_ready completion.

Asynchronous reset asserted mid-operation: immediate abort to the reset values; no partial result is visible.

Decomposition:
- Package mul_b2_seq_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE}.
  - Functions/localparams for D = W/2, CNT_W = clog2(D) (minimum 1), ACC_W = 2W.
- Sub-module mul_b2_comb: purely combinational 2-bit×2-bit unsigned product via a 16-entry table. Output 4 bits; max 3*3=9.
  - The controller registers its output into p_q, which keeps the sequencing and the arithmetic table separable and independently testable.

Test Plan:
- W=8, a=0x03, b=0x05, out_ready=1: accept at edge k → out_valid after edge k+17, q=0x000F; in_ready low from edge k until return to IDLE.
- W=8, a=0xFF, b=0xFF: q=0xFE01. Then a=0x00, b=0xA5 → q=0x0000. Then a=0x80, b=0x02 → q=0x0100.
- Backpressure: finish a=0x12, b=0x34, hold out_ready=0 for 5 cycles → out_valid stays 1, q=0x03A8 stable, in_ready=0 and in_valid pulses ignored. out_ready=1 → IDLE next edge.
- Busy-time stimulus: in_valid with a=0x11 asserted during RUN → no acceptance. The running result is unaffected; a second operation is accepted only once back in IDLE.
- clr at issue 7 of a=0xAB, b=0xCD → IDLE next edge with q=0, out_valid=0. Then a fresh a=0xAB, b=0xCD gives q=0x88EF with full latency.
- rstn pulse low mid-RUN → outputs at reset values immediately (asynchronous). W=4 instance, a=0xF, b=0xF → q=0xE1 after edge k+5.
